if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset (word aligned).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port stall  input  1  hazard hold request from decode/hazard logic.
REQ-005 SHALL have port flush  input  1  squash request; discards the instruction entering IF/ID.
REQ-006 SHALL have port branch_taken  input  1  control-flow redirect request (branch/jal/jalr resolved).
REQ-007 SHALL have port branch_target  input  32  redirect address.
REQ-008 SHALL have port imem_addr  output  32  fetch address to instruction memory, equal to the current PC.
REQ-009 SHALL have port imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-010 SHALL have port pc_out  output  32  PC of the instruction held in IF/ID.
REQ-011 SHALL have port inst_code_out  output  32  instruction held in IF/ID; drives the decode-stage immediate generator and control decoder.
REQ-012 SHALL have port valid_out  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-013 SHALL have port fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Function
REQ-014 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally.
REQ-015 SHALL evaluate each rising edge in priority order: reset > branch_taken > flush > stall > normal advance.
REQ-016 On branch_taken=1: PC <= {branch_target[31:2], 2'b00}; IF/ID <= bubble; stall and flush ignored that cycle.
REQ-017 On flush=1 with branch_taken=0: IF/ID <= bubble; PC <= PC+4 if stall=0, else PC unchanged.
REQ-018 On stall=1 with branch_taken=0 and flush=0: PC, pc_out, inst_code_out, valid_out, fetch_count all unchanged.
REQ-019 On normal advance: PC <= PC+4; pc_out <= PC; inst_code_out <= imem_rdata; valid_out <= 1; fetch_count <= fetch_count+1.
REQ-020 Bubble SHALL mean inst_code_out = 32'h0000_0013 (addi x0,x0,0), pc_out = 32'h0, valid_out = 0; fetch_count unchanged.
REQ-021 PC+4 SHALL be modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-022 Fetch-to-decode latency SHALL be exactly one cycle: the word on imem_rdata while imem_addr = A appears on inst_code_out after the next edge with pc_out = A.
REQ-023 No output SHALL depend combinationally on stall, flush, branch_taken or branch_target; only imem_addr is combinational (from PC).

Reset
REQ-024 While rst_n=0 at a rising edge: PC <= RESET_PC, pc_out <= 0, inst_code_out <= 32'h0000_0013, valid_out <= 0, fetch_count <= 0, regardless of all other inputs.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight instruction and redirect; first normal advance after release fetches RESET_PC.
REQ-026 No state SHALL change asynchronously to clk.

Verification
REQ-027 Reset release, imem_rdata=32'h0050_0093, no stall/flush/branch -> first edge: inst_code_out=32'h0050_0093, pc_out=0, valid_out=1, imem_addr=4, fetch_count=1.
REQ-028 Steady fetch then stall=1 for 2 edges -> PC, pc_out, inst_code_out, valid_out, fetch_count frozen; stall=0 -> resumes at held PC.
REQ-029 branch_taken=1, branch_target=32'h0000_0103, stall=1 same edge -> imem_addr=32'h0000_0100, valid_out=0, inst_code_out=32'h0000_0013, fetch_count unchanged.
REQ-030 flush=1 and stall=1 with PC=32'h20 -> bubble in IF/ID, imem_addr stays 32'h20; flush=1 alone with PC=32'h20 -> bubble, imem_addr=32'h24.
REQ-031 RESET_PC=32'hFFFF_FFFC -> after first advance pc_out=32'hFFFF_FFFC, imem_addr=32'h0000_0000.
REQ-032 rst_n=0 for one edge while PC=32'h40, valid_out=1, fetch_count=5 -> PC=RESET_PC, valid_out=0, inst_code_out=32'h0000_0013, fetch_count=0.

Source files
------------

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction fetch stage plus the IF/ID pipeline register of a 5-stage
// RV32 pipeline. Holds the program counter, presents it to instruction
// memory, and captures the returned word together with its PC into IF/ID
// so decode sees it one cycle after it was fetched.
//
// Parameters
//    RESET_PC       word-aligned fetch address loaded on reset
//
// Ports
//    clk            single clock, all state updates on its rising edge
//    rst_n          synchronous active-low reset
//    stall          hold PC and IF/ID unchanged (hazard hold)
//    flush          squash the instruction entering IF/ID (insert bubble)
//    branch_taken   redirect fetch to branch_target and squash IF/ID
//    branch_target  redirect address (low two bits ignored)
//    imem_addr      fetch address to instruction memory (= PC)
//    imem_rdata     instruction word for imem_addr, same cycle
//    pc_out         PC of the instruction held in IF/ID
//    inst_code_out  instruction held in IF/ID
//    valid_out      1 = IF/ID holds a real instruction, 0 = bubble
//    fetch_count    instructions accepted into IF/ID since reset
// ---------------------------------------------------------------------------
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] inst_code_out,
   output logic        valid_out,
   output logic [31:0] fetch_count
);

   // addi x0,x0,0 -- the canonical RISC-V nop used to fill a bubble
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [31:0] pc;
   logic [31:0] pc_plus4;

   // The sequential next-PC adder wraps naturally modulo 2^32, so the
   // top-of-memory fetch rolls over to address zero.
   always_comb begin
      pc_plus4  = pc + 32'd4;
      imem_addr = pc;
   end

   // PC and IF/ID register update. Priority is reset, then redirect, then
   // flush, then stall, then a normal advance. A redirect overrides stall
   // and flush because the fetched word belongs to the wrong path anyway.
   // A flush still lets the PC move on unless decode is also stalling, in
   // which case the current fetch address must be retried.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         pc_out        <= 32'h0;
         inst_code_out <= NOP_INST;
         valid_out     <= 1'b0;
         fetch_count   <= 32'h0;
      end else if (branch_taken) begin
         pc            <= {branch_target[31:2], 2'b00};
         pc_out        <= 32'h0;
         inst_code_out <= NOP_INST;
         valid_out     <= 1'b0;
      end else if (flush) begin
         if (!stall) begin
            pc <= pc_plus4;
         end
         pc_out        <= 32'h0;
         inst_code_out <= NOP_INST;
         valid_out     <= 1'b0;
      end else if (!stall) begin
         pc            <= pc_plus4;
         pc_out        <= pc;
         inst_code_out <= imem_rdata;
         valid_out     <= 1'b1;
         fetch_count   <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed self-checking bench for if_id_stage. One instance uses the
// default reset PC and walks through advance, stall, redirect, flush and
// mid-run reset; a second instance uses a top-of-memory reset PC to show
// the PC+4 wrap.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] inst_code_out;
   logic        valid_out;
   logic [31:0] fetch_count;

   // second instance: its own reset and fetch data, control tied quiet
   logic        rst_n_w;
   logic        zero_bit;
   logic [31:0] zero_word;
   logic [31:0] imem_addr_w;
   logic [31:0] imem_rdata_w;
   logic [31:0] pc_out_w;
   logic [31:0] inst_code_out_w;
   logic        valid_out_w;
   logic [31:0] fetch_count_w;

   int checks;
   int failures;

   if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc_out        (pc_out),
      .inst_code_out (inst_code_out),
      .valid_out     (valid_out),
      .fetch_count   (fetch_count)
   );

   if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk           (clk),
      .rst_n         (rst_n_w),
      .stall         (zero_bit),
      .flush         (zero_bit),
      .branch_taken  (zero_bit),
      .branch_target (zero_word),
      .imem_addr     (imem_addr_w),
      .imem_rdata    (imem_rdata_w),
      .pc_out        (pc_out_w),
      .inst_code_out (inst_code_out_w),
      .valid_out     (valid_out_w),
      .fetch_count   (fetch_count_w)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // counts one comparison and reports it if the value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // sets the control inputs and fetch data of the main instance
   task automatic applyStimulus(input logic rst, input logic stl,
                                input logic fls, input logic br,
                                input logic [31:0] tgt,
                                input logic [31:0] rdata);
      rst_n         = rst;
      stall         = stl;
      flush         = fls;
      branch_taken  = br;
      branch_target = tgt;
      imem_rdata    = rdata;
   endtask

   // advance one edge, then sample 1 ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      zero_bit     = 1'b0;
      zero_word    = 32'h0;
      rst_n_w      = 1'b0;
      imem_rdata_w = 32'hABCD_0001;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0F00, 32'hDEAD_BEEF);

      // reset dominates even with every other input active
      step();
      step();
      checkOutput("rst_addr",  imem_addr, 32'h0);
      checkOutput("rst_pc",    pc_out, 32'h0);
      checkOutput("rst_inst",  inst_code_out, 32'h0000_0013);
      checkOutput("rst_valid", {31'h0, valid_out}, 32'h0);
      checkOutput("rst_count", fetch_count, 32'h0);
      checkOutput("wrap_rst_addr", imem_addr_w, 32'hFFFF_FFFC);

      // first fetch after release
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
      step();
      checkOutput("adv1_inst",  inst_code_out, 32'h0050_0093);
      checkOutput("adv1_pc",    pc_out, 32'h0);
      checkOutput("adv1_valid", {31'h0, valid_out}, 32'h1);
      checkOutput("adv1_addr",  imem_addr, 32'h4);
      checkOutput("adv1_count", fetch_count, 32'h1);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1111);
      step();
      checkOutput("adv2_pc",    pc_out, 32'h4);
      checkOutput("adv2_inst",  inst_code_out, 32'h1111_1111);
      checkOutput("adv2_count", fetch_count, 32'h2);

      // two stalled edges freeze everything
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
      for (int i = 0; i < 2; i++) begin
         step();
         checkOutput("stall_addr",  imem_addr, 32'h8);
         checkOutput("stall_pc",    pc_out, 32'h4);
         checkOutput("stall_inst",  inst_code_out, 32'h1111_1111);
         checkOutput("stall_valid", {31'h0, valid_out}, 32'h1);
         checkOutput("stall_count", fetch_count, 32'h2);
      end

      // resume at the held PC
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
      step();
      checkOutput("resume_pc",    pc_out, 32'h8);
      checkOutput("resume_inst",  inst_code_out, 32'h3333_3333);
      checkOutput("resume_addr",  imem_addr, 32'hC);
      checkOutput("resume_count", fetch_count, 32'h3);

      // redirect wins over stall; target low bits dropped
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h7777_7777);
      step();
      checkOutput("br_addr",  imem_addr, 32'h0000_0100);
      checkOutput("br_valid", {31'h0, valid_out}, 32'h0);
      checkOutput("br_inst",  inst_code_out, 32'h0000_0013);
      checkOutput("br_pc",    pc_out, 32'h0);
      checkOutput("br_count", fetch_count, 32'h3);

      // redirect also wins over flush
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_001F, 32'h7777_7777);
      step();
      checkOutput("br2_addr", imem_addr, 32'h1C);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
      step();
      checkOutput("adv3_pc",    pc_out, 32'h1C);
      checkOutput("adv3_addr",  imem_addr, 32'h20);
      checkOutput("adv3_count", fetch_count, 32'h4);

      // flush with stall: bubble, PC held
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
      step();
      checkOutput("flst_addr",  imem_addr, 32'h20);
      checkOutput("flst_valid", {31'h0, valid_out}, 32'h0);
      checkOutput("flst_inst",  inst_code_out, 32'h0000_0013);
      checkOutput("flst_pc",    pc_out, 32'h0);
      checkOutput("flst_count", fetch_count, 32'h4);

      // flush alone: bubble, PC advances
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_5555);
      step();
      checkOutput("fl_addr",  imem_addr, 32'h24);
      checkOutput("fl_valid", {31'h0, valid_out}, 32'h0);
      checkOutput("fl_count", fetch_count, 32'h4);

      // set up PC=0x40 with a valid instruction and five fetches
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 32'h0);
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h6666_6666);
      step();
      checkOutput("pre_addr",  imem_addr, 32'h40);
      checkOutput("pre_pc",    pc_out, 32'h3C);
      checkOutput("pre_valid", {31'h0, valid_out}, 32'h1);
      checkOutput("pre_count", fetch_count, 32'h5);

      // mid-run reset for one edge, redirect also requested
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h8888_8888);
      step();
      checkOutput("mrst_addr",  imem_addr, 32'h0);
      checkOutput("mrst_valid", {31'h0, valid_out}, 32'h0);
      checkOutput("mrst_inst",  inst_code_out, 32'h0000_0013);
      checkOutput("mrst_pc",    pc_out, 32'h0);
      checkOutput("mrst_count", fetch_count, 32'h0);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h9999_9999);
      step();
      checkOutput("post_pc",    pc_out, 32'h0);
      checkOutput("post_inst",  inst_code_out, 32'h9999_9999);
      checkOutput("post_addr",  imem_addr, 32'h4);
      checkOutput("post_count", fetch_count, 32'h1);

      // top-of-memory reset PC wraps to zero after the first advance
      rst_n_w = 1'b1;
      step();
      checkOutput("wrap_pc",    pc_out_w, 32'hFFFF_FFFC);
      checkOutput("wrap_addr",  imem_addr_w, 32'h0);
      checkOutput("wrap_inst",  inst_code_out_w, 32'hABCD_0001);
      checkOutput("wrap_valid", {31'h0, valid_out_w}, 32'h1);
      checkOutput("wrap_count", fetch_count_w, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
